// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte-frame command parser driving register file, ALU and TX FIFO
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   RX_P_DATA / RX_D_VLD          received byte and its one-cycle valid
//   RF_RD_DATA / RF_RD_DATA_VLD   register-file read response
//   ALU_OUT / ALU_OUT_VLD         ALU result response
//   FIFO_FULL                     TX FIFO full, stalls pushes
//   RF_ADDR, RF_WR_DATA           register-file address / write data (held)
//   RF_WR_EN, RF_RD_EN            one-cycle register-file strobes
//   ALU_FUN, ALU_EN               ALU function (held) and one-cycle start
//   CLK_GATE_EN                   ALU clock enable while a result is awaited
//   TX_P_DATA, TX_D_VLD           byte and one-cycle push toward TX FIFO
//   CMD_ERR                       one-cycle pulse on unknown command or timeout

module uart_cmd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
    input  logic                     RF_RD_DATA_VLD,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]    RF_ADDR,
    output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
    output logic                     RF_WR_EN,
    output logic                     RF_RD_EN,
    output logic [3:0]               ALU_FUN,
    output logic                     ALU_EN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     CMD_ERR
);

    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_ADDR  = 4'd1;
    localparam logic [3:0] ST_WR_DATA  = 4'd2;
    localparam logic [3:0] ST_RD_ADDR  = 4'd3;
    localparam logic [3:0] ST_RD_WAIT  = 4'd4;
    localparam logic [3:0] ST_RD_SEND  = 4'd5;
    localparam logic [3:0] ST_ALU_A    = 4'd6;
    localparam logic [3:0] ST_ALU_B    = 4'd7;
    localparam logic [3:0] ST_ALU_FUN  = 4'd8;
    localparam logic [3:0] ST_ALU_WAIT = 4'd9;
    localparam logic [3:0] ST_SEND_LO  = 4'd10;
    localparam logic [3:0] ST_SEND_HI  = 4'd11;

    logic [3:0]               state;
    logic [CNT_W-1:0]         wait_cnt;
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [ALU_OUT_WIDTH-1:0] alu_res;
    logic                     wait_expired;

    // Last wait cycle: the counter was cleared on entry, so WAIT_TIMEOUT
    // cycles have elapsed once it reads WAIT_TIMEOUT-1 here.
    assign wait_expired = (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            wr_addr     <= '0;
            rd_data     <= '0;
            alu_res     <= '0;
            RF_ADDR     <= '0;
            RF_WR_DATA  <= '0;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            CMD_ERR     <= 1'b0;
        end else begin
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;
            CMD_ERR  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_WR:     state <= ST_WR_ADDR;
                            CMD_RD:     state <= ST_RD_ADDR;
                            CMD_ALU_OP: state <= ST_ALU_A;
                            CMD_ALU:    state <= ST_ALU_FUN;
                            default:    CMD_ERR <= 1'b1;
                        endcase
                    end
                end

                ST_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        wr_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state   <= ST_WR_DATA;
                    end
                end

                ST_WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= wr_addr;
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= ST_IDLE;
                    end
                end

                ST_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RD_EN <= 1'b1;
                        RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        wait_cnt <= '0;
                        state    <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    // A response on the final wait cycle still beats the timeout.
                    if (RF_RD_DATA_VLD) begin
                        rd_data <= RF_RD_DATA;
                        state   <= ST_RD_SEND;
                    end else if (wait_expired) begin
                        CMD_ERR <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_RD_SEND: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= rd_data;
                        state     <= ST_IDLE;
                    end
                end

                // Operands land in register-file locations 0 and 1 where the ALU reads them.
                ST_ALU_A: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= '0;
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= ST_ALU_B;
                    end
                end

                ST_ALU_B: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= ADDR_WIDTH'(1);
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= ST_ALU_FUN;
                    end
                end

                ST_ALU_FUN: begin
                    if (RX_D_VLD) begin
                        ALU_EN      <= 1'b1;
                        ALU_FUN     <= RX_P_DATA[3:0];
                        CLK_GATE_EN <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= ST_ALU_WAIT;
                    end
                end

                ST_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        alu_res     <= ALU_OUT;
                        CLK_GATE_EN <= 1'b0;
                        state       <= ST_SEND_LO;
                    end else if (wait_expired) begin
                        CMD_ERR     <= 1'b1;
                        CLK_GATE_EN <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_SEND_LO: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= alu_res[DATA_WIDTH-1:0];
                        state     <= ST_SEND_HI;
                    end
                end

                ST_SEND_HI: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl with a frame-level reference model

module tb_uart_cmd_ctrl;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  rd_data;
    logic        rd_vld;
    logic [15:0] alu_out;
    logic        alu_vld;
    logic        fifo_full;

    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic        clk_gate_en;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        cmd_err;

    uart_cmd_ctrl dut (
        .CLK            (clk),
        .RST            (rst),
        .RX_P_DATA      (rx_data),
        .RX_D_VLD       (rx_vld),
        .RF_RD_DATA     (rd_data),
        .RF_RD_DATA_VLD (rd_vld),
        .ALU_OUT        (alu_out),
        .ALU_OUT_VLD    (alu_vld),
        .FIFO_FULL      (fifo_full),
        .RF_ADDR        (rf_addr),
        .RF_WR_DATA     (rf_wr_data),
        .RF_WR_EN       (rf_wr_en),
        .RF_RD_EN       (rf_rd_en),
        .ALU_FUN        (alu_fun),
        .ALU_EN         (alu_en),
        .CLK_GATE_EN    (clk_gate_en),
        .TX_P_DATA      (tx_data),
        .TX_D_VLD       (tx_vld),
        .CMD_ERR        (cmd_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: collects a command frame as a list of bytes and acts once
    // the frame is long enough; responses become a queue of bytes to push.
    typedef enum {M_ACCEPT, M_RD_WAIT, M_ALU_WAIT, M_SEND} mode_t;
    mode_t      mode;
    logic [7:0] frame[$];
    logic [7:0] tx_q[$];
    int         wait_n;

    logic [3:0] e_addr;
    logic [7:0] e_wdata;
    logic       e_wr_en, e_rd_en, e_alu_en, e_gate, e_tx_vld, e_err;
    logic [3:0] e_fun;
    logic [7:0] e_txd;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mode = M_ACCEPT; frame.delete(); tx_q.delete(); wait_n = 0;
            e_addr = 0; e_wdata = 0; e_wr_en = 0; e_rd_en = 0; e_alu_en = 0;
            e_gate = 0; e_tx_vld = 0; e_err = 0; e_fun = 0; e_txd = 0;
        end else begin
            e_wr_en = 0; e_rd_en = 0; e_alu_en = 0; e_tx_vld = 0; e_err = 0;
            case (mode)
                M_ACCEPT: if (rx_vld) begin
                    logic [7:0] b;
                    frame.push_back(rx_data);
                    b = frame[frame.size()-1];
                    case (frame[0])
                        8'hAA: if (frame.size() == 3) begin
                            logic [7:0] a;
                            a = frame[1];
                            e_wr_en = 1; e_addr = a[3:0]; e_wdata = b; frame.delete();
                        end
                        8'hBB: if (frame.size() == 2) begin
                            e_rd_en = 1; e_addr = b[3:0]; mode = M_RD_WAIT; wait_n = 0; frame.delete();
                        end
                        8'hCC: begin
                            if (frame.size() == 2 || frame.size() == 3) begin
                                e_wr_en = 1; e_addr = 4'(frame.size() - 2); e_wdata = b;
                            end else if (frame.size() == 4) begin
                                e_alu_en = 1; e_fun = b[3:0]; mode = M_ALU_WAIT; wait_n = 0; frame.delete();
                            end
                        end
                        8'hDD: if (frame.size() == 2) begin
                            e_alu_en = 1; e_fun = b[3:0]; mode = M_ALU_WAIT; wait_n = 0; frame.delete();
                        end
                        default: begin e_err = 1; frame.delete(); end
                    endcase
                end
                M_RD_WAIT: begin
                    wait_n++;
                    if (rd_vld) begin tx_q.push_back(rd_data); mode = M_SEND; end
                    else if (wait_n >= TMO) begin e_err = 1; mode = M_ACCEPT; end
                end
                M_ALU_WAIT: begin
                    wait_n++;
                    if (alu_vld) begin
                        tx_q.push_back(alu_out[7:0]); tx_q.push_back(alu_out[15:8]); mode = M_SEND;
                    end else if (wait_n >= TMO) begin e_err = 1; mode = M_ACCEPT; end
                end
                M_SEND: if (!fifo_full) begin
                    e_tx_vld = 1; e_txd = tx_q.pop_front();
                    if (tx_q.size() == 0) mode = M_ACCEPT;
                end
                default: mode = M_ACCEPT;
            endcase
            e_gate = (mode == M_ALU_WAIT);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rf_addr",     16'(rf_addr),     16'(e_addr));
            check("rf_wr_data",  16'(rf_wr_data),  16'(e_wdata));
            check("rf_wr_en",    16'(rf_wr_en),    16'(e_wr_en));
            check("rf_rd_en",    16'(rf_rd_en),    16'(e_rd_en));
            check("alu_fun",     16'(alu_fun),     16'(e_fun));
            check("alu_en",      16'(alu_en),      16'(e_alu_en));
            check("clk_gate_en", 16'(clk_gate_en), 16'(e_gate));
            check("tx_data",     16'(tx_data),     16'(e_txd));
            check("tx_vld",      16'(tx_vld),      16'(e_tx_vld));
            check("cmd_err",     16'(cmd_err),     16'(e_err));
        end
    end

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] mdl, input logic [15:0] exp);
        check({nm, "_dut"}, act, exp);
        check({nm, "_model"}, mdl, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_vld = 1'b1;
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] cmds[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        rst = 1; rx_data = 0; rx_vld = 0; rd_data = 0; rd_vld = 0;
        alu_out = 0; alu_vld = 0; fifo_full = 0;
        @(negedge clk);
        chk_en = 1'b1;
        lit("reset_wr_en", 16'(rf_wr_en), 16'(e_wr_en), 16'h0);
        lit("reset_tx_vld", 16'(tx_vld), 16'(e_tx_vld), 16'h0);
        lit("reset_rf_addr", 16'(rf_addr), 16'(e_addr), 16'h0);
        @(negedge clk);
        rst = 0;
        idle(2);

        // register write
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        lit("wr_en", 16'(rf_wr_en), 16'(e_wr_en), 16'h1);
        lit("wr_addr", 16'(rf_addr), 16'(e_addr), 16'h5);
        lit("wr_data", 16'(rf_wr_data), 16'(e_wdata), 16'h3C);
        idle(1);
        lit("wr_en_once", 16'(rf_wr_en), 16'(e_wr_en), 16'h0);
        idle(2);

        // register read, response 3 cycles after the read strobe
        send_byte(8'hBB); send_byte(8'h07);
        lit("rd_en", 16'(rf_rd_en), 16'(e_rd_en), 16'h1);
        lit("rd_addr", 16'(rf_addr), 16'(e_addr), 16'h7);
        idle(3);
        rd_vld = 1; rd_data = 8'h5A;
        @(negedge clk); rd_vld = 0;
        @(negedge clk);
        lit("rd_tx_vld", 16'(tx_vld), 16'(e_tx_vld), 16'h1);
        lit("rd_tx_data", 16'(tx_data), 16'(e_txd), 16'h5A);
        idle(2);

        // ALU with operands
        send_byte(8'hCC);
        send_byte(8'h12);
        lit("op_a_addr", 16'(rf_addr), 16'(e_addr), 16'h0);
        lit("op_a_data", 16'(rf_wr_data), 16'(e_wdata), 16'h12);
        send_byte(8'h34);
        lit("op_b_addr", 16'(rf_addr), 16'(e_addr), 16'h1);
        lit("op_b_data", 16'(rf_wr_data), 16'(e_wdata), 16'h34);
        send_byte(8'h02);
        lit("alu_en", 16'(alu_en), 16'(e_alu_en), 16'h1);
        lit("alu_fun", 16'(alu_fun), 16'(e_fun), 16'h2);
        lit("gate_on", 16'(clk_gate_en), 16'(e_gate), 16'h1);
        idle(2);
        lit("gate_wait", 16'(clk_gate_en), 16'(e_gate), 16'h1);
        alu_vld = 1; alu_out = 16'hABCD;
        @(negedge clk); alu_vld = 0;
        lit("gate_off", 16'(clk_gate_en), 16'(e_gate), 16'h0);
        @(negedge clk);
        lit("alu_lo", 16'({tx_vld, tx_data}), 16'({e_tx_vld, e_txd}), 16'h1CD);
        @(negedge clk);
        lit("alu_hi", 16'({tx_vld, tx_data}), 16'({e_tx_vld, e_txd}), 16'h1AB);
        idle(2);

        // backpressure
        send_byte(8'hDD); send_byte(8'h01);
        idle(1);
        alu_vld = 1; alu_out = 16'h1234; fifo_full = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); alu_vld = 0;
            lit("bp_hold", 16'(tx_vld), 16'(e_tx_vld), 16'h0);
        end
        fifo_full = 0;
        @(negedge clk);
        lit("bp_lo", 16'({tx_vld, tx_data}), 16'({e_tx_vld, e_txd}), 16'h134);
        @(negedge clk);
        lit("bp_hi", 16'({tx_vld, tx_data}), 16'({e_tx_vld, e_txd}), 16'h112);
        idle(2);

        // unknown command
        send_byte(8'h55);
        lit("bad_cmd", 16'(cmd_err), 16'(e_err), 16'h1);
        idle(1);
        lit("bad_cmd_once", 16'(cmd_err), 16'(e_err), 16'h0);

        // read timeout, then a write must still work
        send_byte(8'hBB); send_byte(8'h03);
        idle(TMO - 1);
        lit("tmo_early", 16'(cmd_err), 16'(e_err), 16'h0);
        idle(1);
        lit("tmo_err", 16'(cmd_err), 16'(e_err), 16'h1);
        send_byte(8'hAA); send_byte(8'h0F); send_byte(8'h99);
        lit("post_tmo_wr", 16'({rf_wr_en, rf_addr, rf_wr_data}), 16'({e_wr_en, e_addr, e_wdata}), 16'h1F99);
        idle(2);

        // reset mid-frame
        send_byte(8'hAA); send_byte(8'h02);
        rst = 1;
        @(negedge clk);
        rst = 0;
        send_byte(8'h77);
        lit("rst_abort_err", 16'(cmd_err), 16'(e_err), 16'h1);
        lit("rst_abort_wr", 16'(rf_wr_en), 16'(e_wr_en), 16'h0);
        idle(2);

        // random traffic, busy responders
        for (int i = 0; i < 4000; i++) begin
            rx_vld    = ($urandom_range(0, 2) == 0);
            rx_data   = $urandom_range(0, 1) ? cmds[$urandom_range(0, 3)] : 8'($urandom);
            rd_vld    = ($urandom_range(0, 5) == 0);
            rd_data   = 8'($urandom);
            alu_vld   = ($urandom_range(0, 5) == 0);
            alu_out   = 16'($urandom);
            fifo_full = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end

        // random traffic, slow responders so timeouts occur
        for (int i = 0; i < 3000; i++) begin
            rx_vld    = ($urandom_range(0, 3) == 0);
            rx_data   = $urandom_range(0, 1) ? cmds[$urandom_range(0, 3)] : 8'($urandom);
            rd_vld    = ($urandom_range(0, 299) == 0);
            rd_data   = 8'($urandom);
            alu_vld   = ($urandom_range(0, 299) == 0);
            alu_out   = 16'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            rst       = 0;
            @(negedge clk);
        end

        rx_vld = 0; rd_vld = 0; alu_vld = 0; fifo_full = 0; rst = 0;
        idle(300);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command controller sitting directly downstream of the UART receiver (after the RX data synchronizer) and upstream of the UART transmitter's TX FIFO.
- Parses received byte frames into register-file writes and reads, and ALU operations.
- Returns read data and ALU results as bytes toward the TX FIFO.
- Runs entirely in the reference (REF_CLK) domain.

Parameters:
DATA_WIDTH, 8, width of UART bytes and register-file data
ADDR_WIDTH, 4, register-file address width (taken from LSBs of address byte)
ALU_OUT_WIDTH, 16, ALU result width (two bytes, LSB first)
WAIT_TIMEOUT, 255, max cycles to wait for read/ALU response before abort

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle pulse: RX_P_DATA valid
RF_RD_DATA  in  DATA_WIDTH  register-file read data
RF_RD_DATA_VLD  in  1  read data valid pulse
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid pulse
FIFO_FULL  in  1  TX FIFO full; blocks TX_D_VLD
RF_ADDR  out  ADDR_WIDTH  register-file address
RF_WR_DATA  out  DATA_WIDTH  register-file write data
RF_WR_EN  out  1  one-cycle write strobe
RF_RD_EN  out  1  one-cycle read strobe
ALU_FUN  out  4  ALU function select
ALU_EN  out  1  one-cycle ALU start
CLK_GATE_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  out  1  one-cycle push to TX FIFO
CMD_ERR  out  1  one-cycle pulse: unknown command or timeout

Behaviour:
- All outputs registered. After RST high at an edge: every output 0, FSM = IDLE, timeout counter 0. RST mid-frame aborts the frame; no strobe issues.
- Frames (first byte = command):
  - 0xAA: address, data
  - 0xBB: address
  - 0xCC: opA, opB, fun
  - 0xDD: fun
- Byte acceptance: a byte is consumed only on a CLK edge with RX_D_VLD=1 in IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B or ALU_FUN. RX_D_VLD in any wait or send state is dropped.
- IDLE:
  - 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> ALU_A; 0xDD -> ALU_FUN.
  - Any other value: CMD_ERR=1 next cycle, stay IDLE.
- WR_ADDR: latch RX_P_DATA[ADDR_WIDTH-1:0] -> WR_DATA.
- WR_DATA: on byte, next cycle RF_WR_EN=1, RF_ADDR=latched addr, RF_WR_DATA=byte (one cycle) -> IDLE.
- RD_ADDR: on byte, next cycle RF_RD_EN=1 (one cycle), RF_ADDR=byte LSBs -> RD_WAIT.
- RD_WAIT: on RF_RD_DATA_VLD, latch RF_RD_DATA -> RD_SEND.
- RD_SEND: first cycle with FIFO_FULL=0, TX_D_VLD=1 and TX_P_DATA=latched data for one cycle -> IDLE.
- ALU_A: on byte, next cycle RF_WR_EN=1, RF_ADDR=0, RF_WR_DATA=byte -> ALU_B.
- ALU_B: same, with RF_ADDR=1 -> ALU_FUN.
- ALU_FUN: on byte, next cycle ALU_EN=1 (one cycle), ALU_FUN=byte[3:0] (held until next op) -> ALU_WAIT.
- CLK_GATE_EN: 1 from the cycle ALU_EN rises through the cycle ALU_OUT_VLD is sampled, or until timeout; otherwise 0.
- ALU_WAIT: on ALU_OUT_VLD, latch ALU_OUT -> SEND_LO.
- SEND_LO / SEND_HI: push ALU_OUT[7:0], then ALU_OUT[15:8]. Each push is one cycle of TX_D_VLD=1 with FIFO_FULL=0. SEND_HI push is never in the same cycle as the SEND_LO push. Then -> IDLE.
- FIFO_FULL=1 in a send state: TX_D_VLD=0 and hold state/data, no limit.
- Timeout:
  - Counter clears on entering RD_WAIT/ALU_WAIT and increments each cycle there.
  - At WAIT_TIMEOUT cycles without a valid: CMD_ERR=1 one cycle, CLK_GATE_EN=0 -> IDLE.
  - Valid arriving on the timeout cycle wins: data is latched, no error.
- RF_RD_DATA_VLD or ALU_OUT_VLD outside its wait state: ignored.
- Strobes (RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CMD_ERR) never exceed one cycle per event.

Test Plan:
- Reg write: bytes AA,05,3C -> exactly one cycle RF_WR_EN=1, RF_ADDR=5, RF_WR_DATA=0x3C; FSM back to IDLE.
- Reg read: BB,07; RF_RD_DATA=0x5A with VLD 3 cycles after RF_RD_EN -> one RF_RD_EN pulse with RF_ADDR=7, then TX_D_VLD=1 with TX_P_DATA=0x5A.
- ALU with operands: CC,12,34,02; ALU_OUT=0xABCD with VLD 2 cycles after ALU_EN -> writes addr0=0x12, addr1=0x34; ALU_EN with ALU_FUN=2; CLK_GATE_EN high during the wait; TX pushes CD then AB.
- Backpressure: DD,01 with FIFO_FULL=1 held 10 cycles after ALU_OUT_VLD -> no TX_D_VLD until FIFO_FULL falls, then two pushes in order, none lost.
- Errors: byte 0x55 in IDLE -> one CMD_ERR pulse. BB,03 with no RF_RD_DATA_VLD -> CMD_ERR after 255 cycles, back to IDLE, and next AA frame executes.
- Reset mid-frame: AA,02 then RST for one cycle, then 0x77 -> no RF_WR_EN; 0x77 is treated as an unknown command (CMD_ERR).
